// File: rtl/fifo_warb.sv
// ----------------------------------------------------------------------------
// fifo_warb
//
// Write-side arbiter for the asynchronous FIFO. NUM_REQ requesters share the
// single FIFO write port through round-robin, burst-limited grants. The block
// lives entirely in the write clock domain. The FIFO read side is not touched.
//
// Parameters
//   NUM_REQ     number of requesters (2..8)
//   DATA_WIDTH  beat width, equal to the FIFO data width
//   MAX_BURST   maximum beats transferred per grant (1..16)
//
// Ports
//   wclk        write-domain clock, rising edge
//   wrst        synchronous active-high reset
//   req_valid   per-requester beat-valid
//   req_data    packed beats, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   one-hot or zero; beat i taken when req_valid[i] & req_ready[i]
//   wfull       FIFO full flag
//   winc        FIFO write strobe
//   wdata       FIFO write data
//   grant_id    index of the current owner, valid while busy
//   busy        high while a burst is in progress
//
// Optional build macro
//   FIFO_WARB_STATS_EN  adds beat_count (per-requester 16-bit saturating
//                       accepted-beat counters, packed) and stall_count
//                       (saturating count of burst cycles spent with wfull=1).
//                       Arbitration is the same with or without it.
// ----------------------------------------------------------------------------
module fifo_warb #(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_WIDTH = 8,
   parameter  int MAX_BURST  = 4,
   localparam int GW         = $clog2(NUM_REQ)
) (
   input  logic                          wclk,
   input  logic                          wrst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          wfull,
   output logic                          winc,
   output logic [DATA_WIDTH-1:0]         wdata,
   output logic [GW-1:0]                 grant_id,
`ifdef FIFO_WARB_STATS_EN
   output logic                          busy,
   output logic [NUM_REQ*16-1:0]         beat_count,
   output logic [15:0]                   stall_count
`else
   output logic                          busy
`endif
);

   localparam int BW = $clog2(MAX_BURST) + 1;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } state_t;

   state_t          r_state;
   logic [GW-1:0]   r_grant_id;
   logic [GW-1:0]   r_last_id;
   logic [BW-1:0]   r_beat_cnt;

   logic            w_busy;
   logic            w_valid_g;
   logic            w_xfer;
   logic            w_last_beat;
   logic            w_found;
   logic [GW-1:0]   w_idx;
   logic [GW-1:0]   w_pick;

   // -------------------------------------------------------------------------
   // Round-robin pick: first valid requester after the previous owner.
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every always_comb output gets a default before any branch so no
      // path leaves it unassigned, which would otherwise infer a latch.
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx = GW'((int'(r_last_id) + k) % NUM_REQ);
         if (!w_found && req_valid[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Burst datapath. Outputs follow the grant combinationally so a beat can
   // move every cycle; winc can never rise while the FIFO reports full.
   // -------------------------------------------------------------------------
   always_comb begin
      w_busy      = (r_state == S_BURST);
      w_valid_g   = req_valid[r_grant_id];
      w_xfer      = w_busy & w_valid_g & ~wfull;
      w_last_beat = (r_beat_cnt == BW'(MAX_BURST - 1));
   end

   always_comb begin
      req_ready = '0;
      wdata     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_busy && (r_grant_id == GW'(i))) begin
            req_ready[i] = ~wfull;
            wdata        = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign winc     = w_xfer;
   assign busy     = w_busy;
   assign grant_id = r_grant_id;

   // -------------------------------------------------------------------------
   // Control FSM.
   // -------------------------------------------------------------------------
   always_ff @(posedge wclk) begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (wrst) begin
         r_state    <= S_IDLE;
         r_grant_id <= '0;
         r_last_id  <= GW'(NUM_REQ - 1);
         r_beat_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // No beat moves here; this cycle only picks the next owner.
               if (w_found) begin
                  r_grant_id <= w_pick;
                  r_last_id  <= w_pick;
                  r_beat_cnt <= '0;
                  r_state    <= S_BURST;
               end
            end
            S_BURST: begin
               if (w_xfer) begin
                  r_beat_cnt <= r_beat_cnt + BW'(1);
                  if (w_last_beat) begin
                     r_state <= S_IDLE;
                  end
               end else if (!wfull && !w_valid_g) begin
                  // Owner released the port. A full FIFO only stalls the
                  // burst, it never costs the owner its grant.
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef FIFO_WARB_STATS_EN
   // -------------------------------------------------------------------------
   // Statistics counters, all saturating at 16'hFFFF.
   // -------------------------------------------------------------------------
   logic [15:0] r_beat_stat [NUM_REQ];
   logic [15:0] r_stall_stat;

   always_ff @(posedge wclk) begin
      if (wrst) begin
         // NOTE: this counter array is reset explicitly because software
         // expects it to read zero after reset; it is not a storage RAM.
         for (int i = 0; i < NUM_REQ; i++) begin
            r_beat_stat[i] <= '0;
         end
         r_stall_stat <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (w_xfer && (r_grant_id == GW'(i)) && (r_beat_stat[i] != 16'hFFFF)) begin
               r_beat_stat[i] <= r_beat_stat[i] + 16'd1;
            end
         end
         if (w_busy && wfull && (r_stall_stat != 16'hFFFF)) begin
            r_stall_stat <= r_stall_stat + 16'd1;
         end
      end
   end

   always_comb begin
      beat_count = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         beat_count[i*16 +: 16] = r_beat_stat[i];
      end
   end

   assign stall_count = r_stall_stat;
`endif

endmodule

// File: tb/tb_fifo_warb.sv
// ----------------------------------------------------------------------------
// tb_fifo_warb
//
// Directed scenarios for fifo_warb with a scoreboard. Each requester is a
// queue of beats; the expected write stream (owner id + data) is pushed as
// beats are loaded and popped whenever the DUT strobes winc. Per-cycle winc,
// busy and ready histories are compared against hand-derived patterns.
// ----------------------------------------------------------------------------
module tb_fifo_warb;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int MB = 4;
   localparam int GW = 2;

   logic                 wclk = 1'b0;
   logic                 wrst;
   logic                 wfull;
   logic [NR-1:0]        req_valid;
   logic [NR*DW-1:0]     req_data;
   logic [NR-1:0]        req_ready;
   logic                 winc;
   logic [DW-1:0]        wdata;
   logic [GW-1:0]        grant_id;
   logic                 busy;
`ifdef FIFO_WARB_STATS_EN
   logic [NR*16-1:0]     beat_count;
   logic [15:0]          stall_count;
`endif

   fifo_warb #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .MAX_BURST  (MB)
   ) dut (
      .wclk        (wclk),
      .wrst        (wrst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .wfull       (wfull),
      .winc        (winc),
      .wdata       (wdata),
      .grant_id    (grant_id),
`ifdef FIFO_WARB_STATS_EN
      .busy        (busy),
      .beat_count  (beat_count),
      .stall_count (stall_count)
`else
      .busy        (busy)
`endif
   );

   always #5 wclk = ~wclk;

   typedef struct packed {
      logic [GW-1:0] id;
      logic [DW-1:0] data;
   } beat_t;

   beat_t        exp_q [$];
   logic [DW-1:0] src_q [NR][$];
   int           start_at [NR];
   int           checks = 0;
   int           errors = 0;
   int           sc     = 0;
   logic         rst_hold;
   logic [31:0]  full_pat, rst_pat;
   logic [31:0]  winc_hist, busy_hist, rdy_hist;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load(input int id, input logic [DW-1:0] d);
      beat_t b;
      src_q[id].push_back(d);
      b.id   = GW'(id);
      b.data = d;
      exp_q.push_back(b);
   endtask

   // Expected stream is pushed in global write order, so requester queues are
   // filled separately from the scoreboard where the order differs.
   task automatic expect_beat(input int id, input logic [DW-1:0] d);
      beat_t b;
      b.id   = GW'(id);
      b.data = d;
      exp_q.push_back(b);
   endtask

   task automatic drive();
      logic [4:0] si;
      si    = sc[4:0];
      wrst  = rst_hold | ((sc < 32) ? rst_pat[si] : 1'b0);
      wfull = (sc < 32) ? full_pat[si] : 1'b0;
      for (int i = 0; i < NR; i++) begin
         if (sc >= start_at[i] && src_q[i].size() > 0) begin
            req_valid[i]          = 1'b1;
            req_data[i*DW +: DW]  = src_q[i][0];
         end else begin
            req_valid[i]          = 1'b0;
            req_data[i*DW +: DW]  = '0;
         end
      end
   endtask

   // One clock: drive inputs, sample at the falling edge, retire accepted beats.
   task automatic step();
      logic [NR-1:0] acc;
      logic [4:0]    si;
      beat_t         e;
      drive();
      @(negedge wclk);
      si  = sc[4:0];
      acc = req_valid & req_ready;
      if (sc < 32) begin
         winc_hist[si] = winc;
         busy_hist[si] = busy;
         rdy_hist[si]  = |req_ready;
      end
      if (wfull) check("no_write_when_full", 32'(winc), 32'd0);
      if (!busy) check("wdata_idle_zero", 32'(wdata), 32'd0);
      if (winc) begin
         check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wdata", 32'(wdata), 32'(e.data));
            check("grant_id", 32'(grant_id), 32'(e.id));
         end
      end
      @(posedge wclk);
      #1;
      for (int i = 0; i < NR; i++) begin
         if (acc[i]) void'(src_q[i].pop_front());
      end
      sc++;
   endtask

   task automatic begin_scn();
      sc        = 0;
      full_pat  = '0;
      rst_pat   = '0;
      winc_hist = '0;
      busy_hist = '0;
      rdy_hist  = '0;
      for (int i = 0; i < NR; i++) start_at[i] = 0;
   endtask

   task automatic do_reset();
      begin_scn();
      rst_hold = 1'b1;
      for (int i = 0; i < NR; i++) src_q[i].delete();
      exp_q.delete();
      step();
      step();
      rst_hold = 1'b0;
      begin_scn();
   endtask

   initial begin
      wrst      = 1'b1;
      wfull     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      rst_hold  = 1'b1;
      @(posedge wclk);
      #1;
      do_reset();

      // Reset state of all outputs.
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_winc",      32'(winc),      32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_wdata",     32'(wdata),     32'd0);
      check("rst_grant_id",  32'(grant_id),  32'd0);

      // Single requester, six beats: burst of four, one IDLE cycle, then two.
      begin_scn();
      for (int n = 0; n < 6; n++) load(1, 8'(8'h10 + n));
      repeat (10) step();
      check("s1_winc_pattern", winc_hist & 32'h3FF, 32'h0DE);
      check("s1_busy_pattern", busy_hist & 32'h3FF, 32'h1DE);
      check("s1_drained",      32'(exp_q.size()),   32'd0);
      do_reset();

      // All four continuously valid: grants 0,1,2,3,0, four beats each.
      begin_scn();
      for (int i = 0; i < NR; i++)
         for (int n = 0; n < 8; n++) src_q[i].push_back(8'(i*16 + n));
      for (int b = 0; b < 5; b++)
         for (int n = 0; n < 4; n++) expect_beat(b % NR, 8'((b % NR)*16 + (b/NR)*4 + n));
      repeat (25) step();
      check("s2_winc_pattern", winc_hist & 32'h1FFFFFF, 32'({5{5'b11110}}));
      check("s2_busy_pattern", busy_hist & 32'h1FFFFFF, 32'({5{5'b11110}}));
      check("s2_drained",      32'(exp_q.size()),       32'd0);
      do_reset();

      // Requester 2 stalled by wfull for three cycles after its second beat.
      begin_scn();
      for (int n = 0; n < 4; n++) load(2, 8'(8'hA0 + n));
      full_pat = 32'h38;
      repeat (10) step();
      check("s3_winc_pattern", winc_hist & 32'h3FF, 32'h0C6);
      check("s3_busy_pattern", busy_hist & 32'h3FF, 32'h0FE);
      check("s3_ready_stall",  rdy_hist & 32'h38,   32'd0);
      check("s3_drained",      32'(exp_q.size()),   32'd0);
      do_reset();

      // Requester 3 releases after one beat while requester 0 waits.
      begin_scn();
      load(2, 8'h20);
      start_at[3] = 2;
      start_at[0] = 2;
      load(3, 8'h30);
      load(0, 8'h01);
      load(0, 8'h02);
      repeat (11) step();
      check("s4_winc_pattern", winc_hist & 32'h7FF, 32'h192);
      check("s4_busy_pattern", busy_hist & 32'h7FF, 32'h3B6);
      check("s4_drained",      32'(exp_q.size()),   32'd0);
      do_reset();

      // Reset pulsed during beat 2: next cycle idle, re-arbitration picks 0.
      begin_scn();
      for (int i = 0; i < NR; i++)
         for (int n = 0; n < 8; n++) src_q[i].push_back(8'(i*16 + n));
      for (int n = 0; n < 6; n++) expect_beat(0, 8'(n));
      rst_pat = 32'h4;
      repeat (8) step();
      check("s5_busy_after_rst", 32'(busy_hist[3]), 32'd0);
      check("s5_winc_after_rst", 32'(winc_hist[3]), 32'd0);
      check("s5_winc_pattern",   winc_hist & 32'hFF, 32'hF6);
      check("s5_drained",        32'(exp_q.size()),  32'd0);
      do_reset();

      // Twenty beats, five per requester: full bursts then single-beat bursts.
      begin_scn();
      for (int i = 0; i < NR; i++)
         for (int n = 0; n < 5; n++) src_q[i].push_back(8'(i*16 + n));
      for (int i = 0; i < NR; i++)
         for (int n = 0; n < 4; n++) expect_beat(i, 8'(i*16 + n));
      for (int i = 0; i < NR; i++) expect_beat(i, 8'(i*16 + 4));
      repeat (40) step();
      check("s6_winc_pattern", winc_hist, {{4{3'b010}}, {4{5'b11110}}});
      check("s6_drained",      32'(exp_q.size()), 32'd0);
`ifdef FIFO_WARB_STATS_EN
      for (int i = 0; i < NR; i++) check("s6_beat_count", 32'(beat_count[i*16 +: 16]), 32'd5);
      check("s6_stall_count", 32'(stall_count), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_warb.md
# fifo_warb

Write-side arbiter for the asynchronous FIFO. It shares the single FIFO write port (winc/wdata/wfull) among NUM_REQ requesters using round-robin, burst-limited grants, and lives entirely in the write clock domain. It sits in front of the FIFO's write interface, and the read side is untouched.

## Interface
- NUM_REQ, default 4: number of requesters, range 2..8.
- DATA_WIDTH, default 8: beat width; matches the FIFO's DATA_WIDTH.
- MAX_BURST, default 4: maximum beats per grant, range 1..16.

Clock and reset are fixed: one clock, reset synchronous and active-high.

- wclk  input  1  write-domain clock; all state updates on rising edge.
- wrst  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  requester i has a beat on req_data slice i.
- req_data  input  NUM_REQ*DATA_WIDTH  packed beats; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  one-hot or zero; beat i accepted this cycle when req_valid[i] & req_ready[i].
- wfull  input  1  FIFO full flag.
- winc  output  1  FIFO write strobe.
- wdata  output  DATA_WIDTH  FIFO write data.
- grant_id  output  $clog2(NUM_REQ)  index of current owner; valid while busy.
- busy  output  1  high in BURST state.

## Operation
- States: IDLE and BURST. Registers: state, grant_id, last_id, beat_cnt (width $clog2(MAX_BURST)+1).
- Reset values:
  - state = IDLE, grant_id = 0, last_id = NUM_REQ-1, beat_cnt = 0.
  - Outputs: req_ready = 0, winc = 0, busy = 0, wdata = 0.
- IDLE:
  - If any req_valid, select the first asserted index scanning last_id+1, last_id+2, ... modulo NUM_REQ.
  - Load grant_id and last_id with that index, clear beat_cnt, go to BURST.
  - No beat is transferred in IDLE.
- BURST transfer condition: xfer = req_valid[grant_id] & ~wfull.
- BURST outputs, all combinational:
  - winc = xfer.
  - req_ready[grant_id] = ~wfull; every other req_ready bit = 0.
  - wdata = req_data slice grant_id when busy, else 0.
- On xfer, beat_cnt increments.
- The burst ends, returning to IDLE on the next edge, when either:
  - xfer occurs and beat_cnt == MAX_BURST-1; or
  - req_valid[grant_id] == 0 in a cycle where wfull == 0 (requester released the port).
- wfull stall: while wfull=1 the burst holds. No beat is counted, no timeout applies, and ownership is not lost.
- Requester rule: once req_valid is asserted, req_valid and req_data stay stable until req_ready is seen.
- The arbiter never issues winc while wfull=1, so the FIFO is never overrun.

## Timing
- Arbitration latency: 1 cycle. A request seen in IDLE at edge N gives its first possible write in cycle N+1.
- Throughput: 1 beat/cycle within a burst. Each burst is followed by exactly one IDLE cycle.
- Best-case sustained rate with all requesters busy: MAX_BURST/(MAX_BURST+1).
- Fairness: any continuously valid requester is granted within NUM_REQ-1 intervening bursts.
- Simultaneous wfull and the final beat: no transfer happens and the burst continues.
- wrst mid-burst: next edge returns to IDLE with reset values. Any beat not accepted must be re-presented.

## Configuration
- FIFO_WARB_STATS_EN defined:
  - Adds output beat_count, width NUM_REQ*16: per-requester 16-bit saturating counters of accepted beats.
  - Counters clear on wrst and saturate at 16'hFFFF.
  - Adds output stall_count, 16 bits: saturating count of BURST cycles with wfull=1.
- FIFO_WARB_STATS_EN undefined: neither port nor counter exists, and arbitration behaviour is identical.

## Test plan
- Single requester: req_valid=4'b0010 with 6 beats 8'h10..8'h15, MAX_BURST=4.
  - Beats 10..13 written in four consecutive cycles, one IDLE cycle, then 14..15.
  - grant_id=1 for both bursts.
- All four requesters continuously valid:
  - Grants in order 0,1,2,3,0.
  - Each burst is exactly 4 winc pulses separated by one idle cycle.
- wfull asserted for 3 cycles after the 2nd beat of requester 2's burst:
  - winc=0 and req_ready=0 during the stall.
  - Beats 3 and 4 follow, the burst totals 4, and no write occurs while full.
- Requester 3 drops req_valid after 1 beat while req 0 is waiting: burst ends, IDLE, then grant_id=0.
- wrst pulsed during beat 2 of a burst:
  - Next cycle busy=0, winc=0, last_id=NUM_REQ-1.
  - Re-arbitration picks requester 0 first.
- With FIFO_WARB_STATS_EN, run the all-requesters scenario for 20 beats: each beat_count slice reads 5 and stall_count reads 0.
